// File: rtl/slc3_pkg.sv
// Shared encodings, widths and sign-extension helpers for the SLC-3 datapath.
package slc3_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ALUK_ADD  = 2'b00,
    ALUK_AND  = 2'b01,
    ALUK_NOT  = 2'b10,
    ALUK_PASS = 2'b11
  } aluk_e;

  typedef enum logic [1:0] {
    PCMUX_INC  = 2'b00,
    PCMUX_BUS  = 2'b01,
    PCMUX_ADDR = 2'b10,
    PCMUX_HOLD = 2'b11
  } pcmux_e;

  typedef enum logic [1:0] {
    ADDR2_ZERO  = 2'b00,
    ADDR2_OFF6  = 2'b01,
    ADDR2_OFF9  = 2'b10,
    ADDR2_OFF11 = 2'b11
  } addr2mux_e;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;

  function automatic word_t sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  function automatic word_t sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

  function automatic word_t sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

  function automatic word_t sext11(input logic [10:0] v);
    return {{5{v[10]}}, v};
  endfunction

endpackage

// File: rtl/slc3_regfile.sv
// 8x16 register file: one synchronous write port, two combinational read ports.
// Reads see the pre-edge contents, so read-during-write returns the old value.
module slc3_regfile
  import slc3_pkg::*;
#(
  parameter bit REG_RESET_ZERO = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        we,
  input  logic [2:0]  dr,
  input  logic [15:0] din,
  input  logic [2:0]  sr1,
  input  logic [2:0]  sr2,
  output logic [15:0] sr1_data,
  output logic [15:0] sr2_data
);

  word_t regs [8];

  // Reset still blocks writes when the array itself is not cleared.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      if (REG_RESET_ZERO) begin
        for (int i = 0; i < 8; i++) regs[i] <= '0;
      end
    end else if (we) begin
      regs[dr] <= din;
    end
  end

  assign sr1_data = regs[sr1];
  assign sr2_data = regs[sr2];

endmodule

// File: rtl/slc3_datapath.sv
// SLC-3 datapath: PC, MAR, MDR, IR, register file, CC, BEN, LED latch and the shared bus.
// Optional build macro SLC3_BUS_CONTENTION_CHK_EN adds a sticky Bus_Err flag and an assertion.
module slc3_datapath
  import slc3_pkg::*;
#(
  parameter logic [15:0] PC_RESET       = 16'h0000,
  parameter bit          REG_RESET_ZERO = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        LD_IR,
  input  logic        LD_BEN,
  input  logic        LD_CC,
  input  logic        LD_REG,
  input  logic        LD_PC,
  input  logic        LD_LED,
  input  logic        GatePC,
  input  logic        GateMDR,
  input  logic        GateALU,
  input  logic        GateMARMUX,
  input  logic [1:0]  PCMUX,
  input  logic        DRMUX,
  input  logic        SR1MUX,
  input  logic        SR2MUX,
  input  logic        ADDR1MUX,
  input  logic [1:0]  ADDR2MUX,
  input  logic [1:0]  ALUK,
  input  logic        Mem_OE,
  input  logic [15:0] Data_from_SRAM,
  output logic [15:0] MAR,
  output logic [15:0] Data_to_SRAM,
  output logic [15:0] IR,
  output logic [15:0] PC,
  output logic [3:0]  Opcode,
  output logic        IR_5,
  output logic        IR_11,
  output logic        BEN,
  output logic [11:0] LED
`ifdef SLC3_BUS_CONTENTION_CHK_EN
  ,
  output logic        Bus_Err
`endif
);

  word_t      mdr;
  logic [2:0] cc;        // {N, Z, P}
  logic [2:0] cc_next;
  word_t      bus;
  word_t      alu_out;
  word_t      alu_b;
  word_t      addr1;
  word_t      addr2;
  word_t      addr_out;
  word_t      pc_next;
  word_t      sr1_data;
  word_t      sr2_data;
  logic [2:0] sr1;
  logic [2:0] dr;
  logic [3:0] gates;

  assign gates = {GatePC, GateMDR, GateALU, GateMARMUX};

  // Exactly one gate drives the bus; none or several collapse to zero.
  always_comb begin
    bus = '0;
    case (gates)
      4'b1000: bus = PC;
      4'b0100: bus = mdr;
      4'b0010: bus = alu_out;
      4'b0001: bus = addr_out;
      default: bus = '0;
    endcase
  end

  assign sr1 = SR1MUX ? IR[8:6] : IR[11:9];
  assign dr  = DRMUX  ? 3'd7    : IR[11:9];

  slc3_regfile #(
    .REG_RESET_ZERO(REG_RESET_ZERO)
  ) u_regfile (
    .Clk      (Clk),
    .Reset    (Reset),
    .we       (LD_REG),
    .dr       (dr),
    .din      (bus),
    .sr1      (sr1),
    .sr2      (IR[2:0]),
    .sr1_data (sr1_data),
    .sr2_data (sr2_data)
  );

  assign alu_b = SR2MUX ? sext5(IR[4:0]) : sr2_data;

  always_comb begin
    alu_out = '0;
    case (ALUK)
      ALUK_ADD:  alu_out = sr1_data + alu_b;
      ALUK_AND:  alu_out = sr1_data & alu_b;
      ALUK_NOT:  alu_out = ~sr1_data;
      ALUK_PASS: alu_out = sr1_data;
      default:   alu_out = '0;
    endcase
  end

  assign addr1 = ADDR1MUX ? sr1_data : PC;

  always_comb begin
    addr2 = '0;
    case (ADDR2MUX)
      ADDR2_ZERO:  addr2 = '0;
      ADDR2_OFF6:  addr2 = sext6(IR[5:0]);
      ADDR2_OFF9:  addr2 = sext9(IR[8:0]);
      ADDR2_OFF11: addr2 = sext11(IR[10:0]);
      default:     addr2 = '0;
    endcase
  end

  assign addr_out = addr1 + addr2;

  always_comb begin
    pc_next = PC;
    case (PCMUX)
      PCMUX_INC:  pc_next = PC + 16'd1;
      PCMUX_BUS:  pc_next = bus;
      PCMUX_ADDR: pc_next = addr_out;
      PCMUX_HOLD: pc_next = PC;
      default:    pc_next = PC;
    endcase
  end

  always_comb begin
    cc_next = 3'b001;
    if (bus[15])        cc_next = 3'b100;
    else if (bus == '0) cc_next = 3'b010;
  end

  // All destinations sample the same pre-edge bus, CC and IR.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      PC  <= PC_RESET;
      MAR <= '0;
      mdr <= '0;
      IR  <= '0;
      cc  <= 3'b010;
      BEN <= 1'b0;
      LED <= '0;
    end else begin
      if (LD_PC)  PC  <= pc_next;
      if (LD_MAR) MAR <= bus;
      if (LD_MDR) mdr <= Mem_OE ? bus : Data_from_SRAM;
      if (LD_IR)  IR  <= bus;
      if (LD_CC)  cc  <= cc_next;
      if (LD_BEN) BEN <= |(IR[11:9] & cc);
      if (LD_LED) LED <= IR[11:0];
    end
  end

  assign Data_to_SRAM = mdr;
  assign Opcode       = IR[15:12];
  assign IR_5         = IR[5];
  assign IR_11        = IR[11];

`ifdef SLC3_BUS_CONTENTION_CHK_EN
  logic multi_gate;

  assign multi_gate = (gates & (gates - 4'd1)) != 4'd0;

  always_ff @(posedge Clk) begin
    if (Reset)           Bus_Err <= 1'b0;
    else if (multi_gate) Bus_Err <= 1'b1;
  end

  bus_single_driver_a : assert property (@(posedge Clk) disable iff (Reset) !multi_gate)
    else $warning("slc3_datapath: more than one bus gate enabled");
`endif

endmodule

// File: tb/tb_slc3_datapath.sv
// Directed table-driven bench for slc3_datapath: one record per clock cycle, outputs checked after each edge.
module tb_slc3_datapath;
  import slc3_pkg::*;

  localparam logic [7:0] L_MAR = 8'h80, L_MDR = 8'h40, L_IR  = 8'h20, L_BEN = 8'h10;
  localparam logic [7:0] L_CC  = 8'h08, L_REG = 8'h04, L_PC  = 8'h02, L_LED = 8'h01;
  localparam logic [3:0] G_PC  = 4'h8, G_MDR = 4'h4, G_ALU = 4'h2, G_MM = 4'h1;
  localparam logic [3:0] S_DR  = 4'h8, S_SR1 = 4'h4, S_SR2 = 4'h2, S_A1 = 4'h1;

  typedef struct {
    logic [7:0]  ld;
    logic [3:0]  gate;
    logic [1:0]  pcmux;
    logic [1:0]  addr2mux;
    logic [1:0]  aluk;
    logic [3:0]  sel;
    logic        mem_oe;
    logic [15:0] din;
    logic [15:0] e_mar;
    logic [15:0] e_mdr;
    logic [15:0] e_ir;
    logic [15:0] e_pc;
    logic        e_ben;
    logic [11:0] e_led;
  } vec_t;

  // clock / reset
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic        GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0]  PCMUX, ADDR2MUX, ALUK;
  logic        DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE;
  logic [15:0] Data_from_SRAM, MAR, Data_to_SRAM, IR, PC;
  logic [3:0]  Opcode;
  logic        IR_5, IR_11, BEN;
  logic [11:0] LED;
`ifdef SLC3_BUS_CONTENTION_CHK_EN
  logic        Bus_Err;
`endif

  slc3_datapath dut (
    .Clk(Clk), .Reset(Reset),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .Mem_OE(Mem_OE), .Data_from_SRAM(Data_from_SRAM),
    .MAR(MAR), .Data_to_SRAM(Data_to_SRAM), .IR(IR), .PC(PC),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN), .LED(LED)
`ifdef SLC3_BUS_CONTENTION_CHK_EN
    , .Bus_Err(Bus_Err)
`endif
  );

  int tests = 0;
  int failed = 0;
  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] ld, input logic [3:0] gate,
                              input logic [1:0] pcmux, input logic [1:0] addr2mux,
                              input logic [1:0] aluk, input logic [3:0] sel,
                              input logic mem_oe, input logic [15:0] din,
                              input logic [15:0] e_mar, input logic [15:0] e_mdr,
                              input logic [15:0] e_ir, input logic [15:0] e_pc,
                              input logic e_ben, input logic [11:0] e_led);
    vec_t v;
    v.ld = ld; v.gate = gate; v.pcmux = pcmux; v.addr2mux = addr2mux;
    v.aluk = aluk; v.sel = sel; v.mem_oe = mem_oe; v.din = din;
    v.e_mar = e_mar; v.e_mdr = e_mdr; v.e_ir = e_ir; v.e_pc = e_pc;
    v.e_ben = e_ben; v.e_led = e_led;
    return v;
  endfunction

  // driver
  task automatic drive(input vec_t v);
    {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = v.ld;
    {GatePC, GateMDR, GateALU, GateMARMUX} = v.gate;
    {DRMUX, SR1MUX, SR2MUX, ADDR1MUX} = v.sel;
    PCMUX = v.pcmux;
    ADDR2MUX = v.addr2mux;
    ALUK = v.aluk;
    Mem_OE = v.mem_oe;
    Data_from_SRAM = v.din;
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    logic [15:0] ir_e;
    ir_e = v.e_ir;
    chk({tag, ".mar"},  MAR,                 v.e_mar);
    chk({tag, ".mdr"},  Data_to_SRAM,        v.e_mdr);
    chk({tag, ".ir"},   IR,                  v.e_ir);
    chk({tag, ".pc"},   PC,                  v.e_pc);
    chk({tag, ".ben"},  {15'd0, BEN},        {15'd0, v.e_ben});
    chk({tag, ".led"},  {4'd0, LED},         {4'd0, v.e_led});
    chk({tag, ".op"},   {12'd0, Opcode},     {12'd0, ir_e[15:12]});
    chk({tag, ".ir5"},  {15'd0, IR_5},       {15'd0, ir_e[5]});
    chk({tag, ".ir11"}, {15'd0, IR_11},      {15'd0, ir_e[11]});
  endtask

  task automatic step(input vec_t v, input string tag);
    drive(v);
    @(posedge Clk);
    #1;
    check_vec(v, tag);
  endtask

  initial begin
    vec_t idle, rv;
    idle = mk(8'h00, 4'h0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 4'h0, 1'b1, 16'h0000,
              16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 12'h000);

    // fetch
    vecs.push_back(mk(L_MAR|L_PC, G_PC, PCMUX_INC, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 0, 12'h000));
    vecs.push_back(mk(L_MDR, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 0, 16'h1283, 16'h0000, 16'h1283, 16'h0000, 16'h0001, 0, 12'h000));
    vecs.push_back(mk(L_IR, G_MDR, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h0000, 16'h1283, 16'h1283, 16'h0001, 0, 12'h000));
    // R2 = 7FFF via IR[11:9]=2
    vecs.push_back(mk(L_MDR, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 0, 16'h0400, 16'h0000, 16'h0400, 16'h1283, 16'h0001, 0, 12'h000));
    vecs.push_back(mk(L_IR, G_MDR, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h0000, 16'h0400, 16'h0400, 16'h0001, 0, 12'h000));
    vecs.push_back(mk(L_MDR, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 0, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0400, 16'h0001, 0, 12'h000));
    vecs.push_back(mk(L_REG|L_CC, G_MDR, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h0000, 16'h7FFF, 16'h0400, 16'h0001, 0, 12'h000));
    // ADD R5 = R2 + 3
    vecs.push_back(mk(L_MDR, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 0, 16'h1AA3, 16'h0000, 16'h1AA3, 16'h0400, 16'h0001, 0, 12'h000));
    vecs.push_back(mk(L_IR, G_MDR, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h0000, 16'h1AA3, 16'h1AA3, 16'h0001, 0, 12'h000));
    vecs.push_back(mk(L_REG|L_CC, G_ALU, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, S_SR1|S_SR2, 1, 16'h0000, 16'h0000, 16'h1AA3, 16'h1AA3, 16'h0001, 0, 12'h000));
    vecs.push_back(mk(L_BEN, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h0000, 16'h1AA3, 16'h1AA3, 16'h0001, 1, 12'h000));
    vecs.push_back(mk(L_MAR, G_ALU, PCMUX_HOLD, ADDR2_ZERO, ALUK_PASS, 0, 1, 16'h0000, 16'h8002, 16'h1AA3, 16'h1AA3, 16'h0001, 1, 12'h000));
    // branch BRnp with CC N, Z, P
    vecs.push_back(mk(L_MDR, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 0, 16'h0A05, 16'h8002, 16'h0A05, 16'h1AA3, 16'h0001, 1, 12'h000));
    vecs.push_back(mk(L_IR, G_MDR, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h8002, 16'h0A05, 16'h0A05, 16'h0001, 1, 12'h000));
    vecs.push_back(mk(L_BEN, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h8002, 16'h0A05, 16'h0A05, 16'h0001, 1, 12'h000));
    vecs.push_back(mk(L_CC, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h8002, 16'h0A05, 16'h0A05, 16'h0001, 1, 12'h000));
    vecs.push_back(mk(L_BEN, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h8002, 16'h0A05, 16'h0A05, 16'h0001, 0, 12'h000));
    vecs.push_back(mk(L_CC|L_BEN, G_MDR, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h8002, 16'h0A05, 16'h0A05, 16'h0001, 0, 12'h000));
    vecs.push_back(mk(L_BEN, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h8002, 16'h0A05, 16'h0A05, 16'h0001, 1, 12'h000));
    // PC = 0010, then PC + SEXT(IR[8:0])
    vecs.push_back(mk(L_MDR, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 0, 16'h0010, 16'h8002, 16'h0010, 16'h0A05, 16'h0001, 1, 12'h000));
    vecs.push_back(mk(L_PC|L_MAR, G_MDR, PCMUX_BUS, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h0010, 16'h0010, 16'h0A05, 16'h0010, 1, 12'h000));
    vecs.push_back(mk(L_PC, 0, PCMUX_ADDR, ADDR2_OFF9, ALUK_ADD, 0, 1, 16'h0000, 16'h0010, 16'h0010, 16'h0A05, 16'h0015, 1, 12'h000));
    vecs.push_back(mk(L_MAR, G_MM, PCMUX_HOLD, ADDR2_OFF6, ALUK_ADD, 0, 1, 16'h0000, 16'h001A, 16'h0010, 16'h0A05, 16'h0015, 1, 12'h000));
    vecs.push_back(mk(L_PC, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h001A, 16'h0010, 16'h0A05, 16'h0015, 1, 12'h000));
    // two gates at once: bus reads as zero
    vecs.push_back(mk(L_MAR, G_PC|G_MDR, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h0000, 16'h0010, 16'h0A05, 16'h0015, 1, 12'h000));
    // JSR: R7 = PC, PC = PC - 2
    vecs.push_back(mk(L_MDR, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 0, 16'h0020, 16'h0000, 16'h0020, 16'h0A05, 16'h0015, 1, 12'h000));
    vecs.push_back(mk(L_PC, G_MDR, PCMUX_BUS, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h0000, 16'h0020, 16'h0A05, 16'h0020, 1, 12'h000));
    vecs.push_back(mk(L_MDR, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 0, 16'h4FFE, 16'h0000, 16'h4FFE, 16'h0A05, 16'h0020, 1, 12'h000));
    vecs.push_back(mk(L_IR, G_MDR, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h0000, 16'h4FFE, 16'h4FFE, 16'h0020, 1, 12'h000));
    vecs.push_back(mk(L_REG, G_PC, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, S_DR, 1, 16'h0000, 16'h0000, 16'h4FFE, 16'h4FFE, 16'h0020, 1, 12'h000));
    vecs.push_back(mk(L_PC, 0, PCMUX_ADDR, ADDR2_OFF11, ALUK_ADD, 0, 1, 16'h0000, 16'h0000, 16'h4FFE, 16'h4FFE, 16'h001E, 1, 12'h000));
    // ALU functions on R7=0020 (R6=0, imm5=-2)
    vecs.push_back(mk(L_MAR, G_ALU, PCMUX_HOLD, ADDR2_ZERO, ALUK_PASS, 0, 1, 16'h0000, 16'h0020, 16'h4FFE, 16'h4FFE, 16'h001E, 1, 12'h000));
    vecs.push_back(mk(L_MAR, G_ALU, PCMUX_HOLD, ADDR2_ZERO, ALUK_NOT, 0, 1, 16'h0000, 16'hFFDF, 16'h4FFE, 16'h4FFE, 16'h001E, 1, 12'h000));
    vecs.push_back(mk(L_MAR, G_ALU, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, S_SR2, 1, 16'h0000, 16'h001E, 16'h4FFE, 16'h4FFE, 16'h001E, 1, 12'h000));
    vecs.push_back(mk(L_MAR, G_ALU, PCMUX_HOLD, ADDR2_ZERO, ALUK_AND, 0, 1, 16'h0000, 16'h0000, 16'h4FFE, 16'h4FFE, 16'h001E, 1, 12'h000));
    vecs.push_back(mk(L_MAR, G_MM, PCMUX_HOLD, ADDR2_OFF6, ALUK_ADD, S_A1, 1, 16'h0000, 16'h001E, 16'h4FFE, 16'h4FFE, 16'h001E, 1, 12'h000));
    // PC increment wraps
    vecs.push_back(mk(L_MDR, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 0, 16'hFFFF, 16'h001E, 16'hFFFF, 16'h4FFE, 16'h001E, 1, 12'h000));
    vecs.push_back(mk(L_PC, G_MDR, PCMUX_BUS, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h001E, 16'hFFFF, 16'h4FFE, 16'hFFFF, 1, 12'h000));
    vecs.push_back(mk(L_PC, 0, PCMUX_INC, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h001E, 16'hFFFF, 16'h4FFE, 16'h0000, 1, 12'h000));
    vecs.push_back(mk(L_LED, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h001E, 16'hFFFF, 16'h4FFE, 16'h0000, 1, 12'hFFE));
    // STR data path: R3 = BEEF, MDR from bus while SRAM shows 1234
    vecs.push_back(mk(L_MDR, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 0, 16'h7600, 16'h001E, 16'h7600, 16'h4FFE, 16'h0000, 1, 12'hFFE));
    vecs.push_back(mk(L_IR, G_MDR, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h001E, 16'h7600, 16'h7600, 16'h0000, 1, 12'hFFE));
    vecs.push_back(mk(L_MDR, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 0, 16'hBEEF, 16'h001E, 16'hBEEF, 16'h7600, 16'h0000, 1, 12'hFFE));
    vecs.push_back(mk(L_REG, G_MDR, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h001E, 16'hBEEF, 16'h7600, 16'h0000, 1, 12'hFFE));
    vecs.push_back(mk(L_MDR, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 0, 16'h0000, 16'h001E, 16'h0000, 16'h7600, 16'h0000, 1, 12'hFFE));
    vecs.push_back(mk(L_MDR, G_ALU, PCMUX_HOLD, ADDR2_ZERO, ALUK_PASS, 0, 1, 16'h1234, 16'h001E, 16'hBEEF, 16'h7600, 16'h0000, 1, 12'hFFE));
    vecs.push_back(mk(L_LED, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h001E, 16'hBEEF, 16'h7600, 16'h0000, 1, 12'h600));
    // read-during-write returns the old R3
    vecs.push_back(mk(L_REG|L_MAR, G_ALU, PCMUX_HOLD, ADDR2_ZERO, ALUK_NOT, 0, 1, 16'h0000, 16'h4110, 16'hBEEF, 16'h7600, 16'h0000, 1, 12'h600));
    vecs.push_back(mk(L_MAR, G_ALU, PCMUX_HOLD, ADDR2_ZERO, ALUK_NOT, 0, 1, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h7600, 16'h0000, 1, 12'h600));

    drive(idle);
    repeat (2) @(posedge Clk);
    #1;
    check_vec(idle, "reset");
    Reset = 1'b0;

    foreach (vecs[i]) step(vecs[i], $sformatf("v%0d", i));

`ifdef SLC3_BUS_CONTENTION_CHK_EN
    chk("bus_err.sticky", {15'd0, Bus_Err}, 16'h0001);
`endif

    // Reset with every load asserted: nothing but reset values may appear
    rv = mk(8'hFF, G_MDR, PCMUX_INC, ADDR2_ZERO, ALUK_ADD, 0, 0, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 12'h000);
    Reset = 1'b1;
    step(rv, "midreset");
    Reset = 1'b0;
`ifdef SLC3_BUS_CONTENTION_CHK_EN
    chk("bus_err.cleared", {15'd0, Bus_Err}, 16'h0000);
`endif

    // CC back to Z and R2 cleared after reset
    step(mk(L_MDR, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 0, 16'h0400, 16'h0000, 16'h0400, 16'h0000, 16'h0000, 0, 12'h000), "post_mdr");
    step(mk(L_IR, G_MDR, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h0000, 16'h0400, 16'h0400, 16'h0000, 0, 12'h000), "post_ir");
    step(mk(L_BEN, 0, PCMUX_HOLD, ADDR2_ZERO, ALUK_ADD, 0, 1, 16'h0000, 16'h0000, 16'h0400, 16'h0400, 16'h0000, 1, 12'h000), "post_ben");
    step(mk(L_MAR, G_ALU, PCMUX_HOLD, ADDR2_ZERO, ALUK_NOT, 0, 1, 16'h0000, 16'hFFFF, 16'h0400, 16'h0400, 16'h0000, 1, 12'h000), "post_r2");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
